// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - multi-cycle control FSM sequencing fetch, decode, ALU, data memory and register writeback
module regfile_sequencer #(
    parameter int PW = 8,
    parameter int W  = 8,
    parameter int A  = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          InstReq,
    output logic [PW-1:0] InstAddr,
    input  logic          InstValid,
    input  logic [8:0]    Instr,
    input  logic          AluEq,
    input  logic          AluGt,
    input  logic [PW-1:0] BranchTarget,
    output logic          MemReq,
    output logic          MemWrite,
    input  logic          MemAck,
    output logic          AluEn,
    output logic          RegWriteEn,
    output logic          RegOp,
    output logic [3:0]    RegOperation,
    output logic [A-1:0]  RegRtaddr,
    output logic [W-1:0]  Immediate,
    output logic          Done
);

    // Opcode map shared with the RegFile/ALU; anything not listed is an ALU op
    localparam logic [3:0] K_CPP  = 4'h8;
    localparam logic [3:0] K_CYY  = 4'h9;
    localparam logic [3:0] K_LOD  = 4'hA;
    localparam logic [3:0] K_STR  = 4'hB;
    localparam logic [3:0] K_BNE  = 4'hC;
    localparam logic [3:0] K_BGT  = 4'hD;
    localparam logic [3:0] K_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pc;
    logic [PW-1:0] r_target;
    logic [8:0]    r_instr;
    logic          r_taken;

    logic       w_imm;
    logic [3:0] w_opc;
    logic       w_is_lod;
    logic       w_is_str;
    logic       w_is_bne;
    logic       w_is_bgt;
    logic       w_is_halt;
    logic       w_writes;
    logic       w_taken;
    logic       w_fields_on;
    logic       w_start_ok;

    assign w_imm     = r_instr[8];
    assign w_opc     = r_instr[7:4];
    assign w_is_lod  = !w_imm && (w_opc == K_LOD);
    assign w_is_str  = !w_imm && (w_opc == K_STR);
    assign w_is_bne  = !w_imm && (w_opc == K_BNE);
    assign w_is_bgt  = !w_imm && (w_opc == K_BGT);
    assign w_is_halt = !w_imm && (w_opc == K_HALT);
    // Load-imm, LOD, CPP, CYY and every ALU op write back; stores and branches do not
    assign w_writes  = !(w_is_str || w_is_bne || w_is_bgt || w_is_halt);
    assign w_taken   = (w_is_bne && !AluEq) || (w_is_bgt && AluGt);
    assign w_start_ok = ((r_state == S_IDLE) || (r_state == S_HALT)) && Start;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_target <= '0;
            r_instr  <= '0;
            r_taken  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && InstValid) begin
                r_instr <= Instr;
            end
            if (r_state == S_EXEC) begin
                r_taken  <= w_taken;
                r_target <= BranchTarget;
            end
            if (w_start_ok) begin
                r_pc <= '0;
            end else if (r_state == S_WB) begin
                r_pc <= r_taken ? r_target : r_pc + PW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Start) w_next = S_FETCH;
            S_FETCH:  if (InstValid) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_halt) begin
                    w_next = S_HALT;
                end else if (w_is_lod || w_is_str) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM:    if (MemAck) w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   if (Start) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_fields_on = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                         (r_state == S_MEM)    || (r_state == S_WB);

    always_comb begin
        InstReq      = 1'b0;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        AluEn        = 1'b0;
        RegWriteEn   = 1'b0;
        RegOp        = 1'b0;
        RegOperation = 4'h0;
        RegRtaddr    = '0;
        Immediate    = '0;
        Done         = 1'b0;
        InstAddr     = r_pc;
        if (w_fields_on) begin
            RegOp        = w_imm;
            RegOperation = w_opc;
            RegRtaddr    = A'(r_instr[3:0]);
            Immediate    = W'(r_instr[7:0]);
        end
        case (r_state)
            S_FETCH: InstReq = 1'b1;
            S_EXEC:  AluEn   = 1'b1;
            S_MEM: begin
                MemReq   = 1'b1;
                MemWrite = w_is_str;
            end
            S_WB:    RegWriteEn = w_writes;
            S_HALT:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - randomized scoreboard bench for regfile_sequencer
module tb_regfile_sequencer;

    localparam logic [3:0] K_LOD  = 4'hA;
    localparam logic [3:0] K_STR  = 4'hB;
    localparam logic [3:0] K_BNE  = 4'hC;
    localparam logic [3:0] K_BGT  = 4'hD;
    localparam logic [3:0] K_HALT = 4'hF;

    localparam logic [1:0] EV_FETCH = 2'd0;
    localparam logic [1:0] EV_MEM   = 2'd1;
    localparam logic [1:0] EV_WR    = 2'd2;
    localparam logic [1:0] EV_DONE  = 2'd3;

    logic       Clk = 1'b0;
    logic       Reset, Start, InstValid, AluEq, AluGt, MemAck;
    logic [8:0] Instr;
    logic [7:0] BranchTarget;
    logic       InstReq, MemReq, MemWrite, AluEn, RegWriteEn, RegOp, Done;
    logic [7:0] InstAddr, Immediate;
    logic [3:0] RegOperation, RegRtaddr;

    regfile_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .InstReq(InstReq), .InstAddr(InstAddr), .InstValid(InstValid), .Instr(Instr),
        .AluEq(AluEq), .AluGt(AluGt), .BranchTarget(BranchTarget),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAck(MemAck),
        .AluEn(AluEn), .RegWriteEn(RegWriteEn), .RegOp(RegOp),
        .RegOperation(RegOperation), .RegRtaddr(RegRtaddr),
        .Immediate(Immediate), .Done(Done)
    );

    typedef struct packed {
        logic [1:0] kind;
        int         cyc;
        logic [7:0] a;
        logic [3:0] rt;
        logic       op;
        logic [3:0] oper;
        logic [7:0] imm;
        logic       mw;
    } ev_t;

    ev_t        q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] m_pc = 8'h00;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take(input ev_t act);
        ev_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=%0h", act.kind, act.cyc, act.a);
        end else begin
            e = q.pop_front();
            if (e !== act) begin
                n_bad++;
                $display("FAIL event: got kind=%0d cyc=%0d addr=%0h rt=%0h op=%0b oper=%0h imm=%0h mw=%0b expected kind=%0d cyc=%0d addr=%0h rt=%0h op=%0b oper=%0h imm=%0h mw=%0b",
                         act.kind, act.cyc, act.a, act.rt, act.op, act.oper, act.imm, act.mw,
                         e.kind, e.cyc, e.a, e.rt, e.op, e.oper, e.imm, e.mw);
            end
        end
    endtask

    // Monitor: turns observed DUT activity into events and matches them against the queue
    initial begin
        logic p_ir, p_mr, p_dn;
        ev_t  a;
        p_ir = 1'b0; p_mr = 1'b0; p_dn = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (InstReq === 1'b1 && !p_ir) begin
                a = '0; a.kind = EV_FETCH; a.cyc = cyc; a.a = InstAddr; take(a);
            end
            if (MemReq === 1'b1 && !p_mr) begin
                a = '0; a.kind = EV_MEM; a.cyc = cyc; a.rt = RegRtaddr;
                a.oper = RegOperation; a.mw = MemWrite; take(a);
            end
            if (RegWriteEn === 1'b1) begin
                a = '0; a.kind = EV_WR; a.cyc = cyc; a.op = RegOp; a.imm = Immediate;
                if (!RegOp) begin
                    a.rt = RegRtaddr; a.oper = RegOperation;
                end
                take(a);
            end
            if (Done === 1'b1 && !p_dn) begin
                a = '0; a.kind = EV_DONE; a.cyc = cyc; take(a);
            end
            if (RegWriteEn === 1'b1 || MemReq === 1'b1) begin
                check("wr_mem_exclusive", {62'd0, RegWriteEn, MemReq}, {62'd0, ~MemReq, ~RegWriteEn});
            end
            p_ir = (InstReq === 1'b1);
            p_mr = (MemReq === 1'b1);
            p_dn = (Done === 1'b1);
        end
    end

    function automatic logic [8:0] rnd_instr();
        logic [8:0] ins;
        ins = 9'($urandom);
        if (!ins[8] && ins[7:4] == K_HALT && $urandom_range(0, 3) != 0) ins[7:4] = 4'h0;
        return ins;
    endfunction

    function automatic ev_t mk(input logic [1:0] kind, input int c);
        ev_t e;
        e = '0; e.kind = kind; e.cyc = c;
        return e;
    endfunction

    // Called at a negedge in the cycle just before FETCH; pushes the instruction's
    // expected events from the model, then plays ROM/memory open-loop.
    task automatic run_instr(input bit fix, input logic [8:0] fi, input bit feq, input bit fgt,
                             input logic [7:0] ftgt, output bit halted);
        int         s, dv, da;
        logic [8:0] ins;
        logic [7:0] tgt;
        logic [3:0] opc;
        bit         eq, gt, mem;
        ev_t        e;
        s = cyc + 1;
        if (fix) begin
            ins = fi; eq = feq; gt = fgt; tgt = ftgt;
        end else begin
            ins = rnd_instr(); eq = 1'($urandom); gt = 1'($urandom); tgt = 8'($urandom);
        end
        dv = $urandom_range(0, 3);
        da = $urandom_range(0, 3);
        opc = ins[7:4];
        halted = 1'b0;
        mem = 1'b0;
        e = mk(EV_FETCH, s); e.a = m_pc; q.push_back(e);
        if (ins[8]) begin
            e = mk(EV_WR, s + dv + 3); e.op = 1'b1; e.imm = ins[7:0]; q.push_back(e);
            m_pc = m_pc + 8'd1;
        end else if (opc == K_HALT) begin
            q.push_back(mk(EV_DONE, s + dv + 3));
            halted = 1'b1;
        end else if (opc == K_LOD || opc == K_STR) begin
            mem = 1'b1;
            e = mk(EV_MEM, s + dv + 3); e.rt = ins[3:0]; e.oper = opc; e.mw = (opc == K_STR);
            q.push_back(e);
            if (opc == K_LOD) begin
                e = mk(EV_WR, s + dv + 4 + da); e.rt = ins[3:0]; e.oper = opc; e.imm = ins[7:0];
                q.push_back(e);
            end
            m_pc = m_pc + 8'd1;
        end else if (opc == K_BNE) begin
            m_pc = !eq ? tgt : m_pc + 8'd1;
        end else if (opc == K_BGT) begin
            m_pc = gt ? tgt : m_pc + 8'd1;
        end else begin
            e = mk(EV_WR, s + dv + 3); e.rt = ins[3:0]; e.oper = opc; e.imm = ins[7:0];
            q.push_back(e);
            m_pc = m_pc + 8'd1;
        end
        repeat (dv + 1) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        Instr = ins; InstValid = 1'b1; AluEq = eq; AluGt = gt; BranchTarget = tgt;
        @(negedge Clk);
        InstValid = 1'b0; Instr = 9'($urandom); Start = 1'($urandom);
        @(negedge Clk);
        Start = 1'b0; InstValid = 1'($urandom);
        if (!mem) MemAck = 1'($urandom);
        @(negedge Clk);
        MemAck = 1'b0; InstValid = 1'b0;
        if (mem) begin
            repeat (da) @(negedge Clk);
            MemAck = 1'b1;
            @(negedge Clk);
            MemAck = 1'b0;
        end
    endtask

    task automatic step(input bit fix, input logic [8:0] fi, input bit feq, input bit fgt,
                        input logic [7:0] ftgt);
        bit h;
        run_instr(fix, fi, feq, fgt, ftgt, h);
        if (h) begin
            repeat ($urandom_range(1, 3)) begin
                check("done_hold", {63'd0, Done}, 64'd1);
                @(negedge Clk);
            end
            Start = 1'b1;
            m_pc = 8'h00;
        end
    endtask

    initial begin
        ev_t e;
        int  s;
        Reset = 1'b1; Start = 1'b0; InstValid = 1'b0; Instr = '0;
        AluEq = 1'b0; AluGt = 1'b0; MemAck = 1'b0; BranchTarget = '0;
        repeat (3) @(negedge Clk);
        check("reset_outputs",
              {33'd0, InstReq, MemReq, MemWrite, AluEn, RegWriteEn, RegOp, RegOperation,
               RegRtaddr, Immediate, Done, InstAddr}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        Start = 1'b1; m_pc = 8'h00;

        step(1'b1, 9'h15A, 1'b0, 1'b0, 8'h00);
        step(1'b1, {1'b0, K_LOD, 4'h4}, 1'b0, 1'b0, 8'h00);
        step(1'b1, {1'b0, K_STR, 4'h2}, 1'b0, 1'b0, 8'h00);
        step(1'b1, {1'b0, K_BNE, 4'h0}, 1'b0, 1'b0, 8'h20);
        step(1'b1, {1'b0, K_BNE, 4'h0}, 1'b1, 1'b0, 8'h20);
        step(1'b1, {1'b0, K_BGT, 4'h0}, 1'b0, 1'b1, 8'h20);
        step(1'b1, {1'b0, K_BNE, 4'h0}, 1'b0, 1'b0, 8'hFF);
        step(1'b1, {1'b0, 4'h1, 4'h3}, 1'b0, 1'b0, 8'h00);
        step(1'b1, {1'b0, K_HALT, 4'h0}, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) step(1'b0, 9'h0, 1'b0, 1'b0, 8'h00);

        // Reset while the data-memory request is outstanding
        s = cyc + 1;
        e = mk(EV_FETCH, s); e.a = m_pc; q.push_back(e);
        e = mk(EV_MEM, s + 3); e.rt = 4'h4; e.oper = K_LOD; q.push_back(e);
        @(negedge Clk);
        Start = 1'b0; Instr = {1'b0, K_LOD, 4'h4}; InstValid = 1'b1;
        @(negedge Clk);
        InstValid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_mid_mem", {59'd0, MemReq, InstReq, RegWriteEn, Done, AluEn}, 64'd0);
        check("reset_mid_mem_pc", {56'd0, InstAddr}, 64'd0);
        Reset = 1'b0;
        MemAck = 1'b1;
        repeat (3) @(negedge Clk);
        MemAck = 1'b0;
        Start = 1'b1; m_pc = 8'h00;
        step(1'b1, {1'b0, 4'h2, 4'h5}, 1'b0, 1'b0, 8'h00);
        Start = 1'b0;
        e = mk(EV_FETCH, cyc + 1); e.a = m_pc; q.push_back(e);
        repeat (10) @(negedge Clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
